// File: rtl/lane_scorer_pkg.sv
// Shared types and constants for the lane scorer: lane FSM states, point
// values, multiplier tiers and the per-lane key scancodes.
package scoring_pkg;

    typedef enum logic [1:0] {
        WAIT  = 2'd0,
        ARMED = 2'd1,
        DONE  = 2'd2
    } lane_state_t;

    localparam int unsigned PTS_GOOD    = 1;
    localparam int unsigned PTS_PERFECT = 2;
    localparam int unsigned MULT_STEP   = 10;
    localparam int unsigned MULT_MAX    = 4;

    localparam int unsigned MAX_LANES = 5;
    // Index 0 is the rightmost entry: lane 0 answers to scancode 0x04.
    localparam logic [MAX_LANES-1:0][7:0] LANE_KEY = {8'h0A, 8'h09, 8'h07, 8'h16, 8'h04};

    // Streak multiplier: one extra tier every MULT_STEP hits, capped at MULT_MAX.
    function automatic logic [2:0] mult_of(input int unsigned combo);
        int unsigned tier;
        tier = 1 + combo / MULT_STEP;
        return (tier > MULT_MAX) ? 3'(MULT_MAX) : 3'(tier);
    endfunction

endpackage

// File: rtl/lane_scorer_if.sv
// Game-side bus of the lane scorer: note/key inputs from the game engine and
// registered score/combo/event outputs back to it.
interface lane_scorer_if #(
    parameter int unsigned NUM_LANES = 5,
    parameter int unsigned Y_W       = 10,
    parameter int unsigned SCORE_W   = 16,
    parameter int unsigned COMBO_W   = 8
);

    logic                           clear;
    logic [7:0]                     keycode;
    logic [NUM_LANES-1:0][Y_W-1:0]  note_y;
    logic [NUM_LANES-1:0]           note_valid;
    logic [SCORE_W-1:0]             score;
    logic [COMBO_W-1:0]             combo;
    logic [COMBO_W-1:0]             max_combo;
    logic [NUM_LANES-1:0]           hit_pulse;
    logic [NUM_LANES-1:0]           miss_pulse;
    logic                           perfect_pulse;

    modport master (
        output clear, keycode, note_y, note_valid,
        input  score, combo, max_combo, hit_pulse, miss_pulse, perfect_pulse
    );

    modport slave (
        input  clear, keycode, note_y, note_valid,
        output score, combo, max_combo, hit_pulse, miss_pulse, perfect_pulse
    );

endinterface

// File: rtl/lane_scorer_judge.sv
// Per-lane WAIT/ARMED/DONE judge: arms on a note entering the hit window and
// flags a hit (with grade) or a miss for the cycle it is decided.
module lane_judge
    import scoring_pkg::*;
#(
    parameter int unsigned Y_W     = 10,
    parameter int unsigned WIN_LO  = 410,
    parameter int unsigned WIN_HI  = 440,
    parameter int unsigned PERF_LO = 420,
    parameter int unsigned PERF_HI = 430,
    parameter logic [7:0]  KEY     = 8'h04
) (
    input  logic           Clk,
    input  logic           Reset_n,
    input  logic           clear_i,
    input  logic [Y_W-1:0] note_y_i,
    input  logic           note_valid_i,
    input  logic [7:0]     keycode_i,
    input  logic           key_edge_i,
    output logic           hit_o,
    output logic           miss_o,
    output logic           perfect_o
);

    localparam logic [Y_W-1:0] WIN_LO_Y  = Y_W'(WIN_LO);
    localparam logic [Y_W-1:0] WIN_HI_Y  = Y_W'(WIN_HI);
    localparam logic [Y_W-1:0] PERF_LO_Y = Y_W'(PERF_LO);
    localparam logic [Y_W-1:0] PERF_HI_Y = Y_W'(PERF_HI);

    lane_state_t state_q;
    logic        in_win;
    logic        past_win;
    logic        below_win;
    logic        in_perf;

    // Events are decoded combinationally so the top can register score and
    // pulses on the same edge that commits the state change.
    // NOTE: every always_comb output is assigned on every path, so no latches.
    always_comb begin
        in_win    = (note_y_i > WIN_LO_Y) && (note_y_i < WIN_HI_Y);
        past_win  = (note_y_i >= WIN_HI_Y);
        below_win = (note_y_i <= WIN_LO_Y);
        in_perf   = (note_y_i >= PERF_LO_Y) && (note_y_i <= PERF_HI_Y);
        hit_o     = note_valid_i && (state_q == ARMED) && !past_win &&
                    (keycode_i == KEY) && key_edge_i;
        miss_o    = note_valid_i && past_win && (state_q != DONE);
        perfect_o = hit_o && in_perf;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= WAIT;
        end else if (clear_i || !note_valid_i) begin
            state_q <= WAIT;
        end else begin
            case (state_q)
                WAIT:    if (past_win) state_q <= DONE;
                         else if (in_win) state_q <= ARMED;
                ARMED:   if (past_win || hit_o) state_q <= DONE;
                DONE:    if (below_win) state_q <= WAIT;
                default: state_q <= WAIT;
            endcase
        end
    end

endmodule

// File: rtl/lane_scorer.sv
// Rhythm-game scorer: per-lane judges, key press-edge detection, streak
// multiplier (only when SCORER_MULT_EN is defined) and saturating score/combo.
module lane_scorer
    import scoring_pkg::*;
#(
    parameter int unsigned NUM_LANES = 5,
    parameter int unsigned Y_W       = 10,
    parameter int unsigned SCORE_W   = 16,
    parameter int unsigned COMBO_W   = 8,
    parameter int unsigned WIN_LO    = 410,
    parameter int unsigned WIN_HI    = 440,
    parameter int unsigned PERF_LO   = 420,
    parameter int unsigned PERF_HI   = 430
) (
    input  logic         Clk,
    input  logic         Reset_n,
    lane_scorer_if.slave bus
);

    logic [7:0]           prev_key_q;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [COMBO_W-1:0]   combo_q, combo_d;
    logic [COMBO_W-1:0]   max_q, max_d;
    logic [NUM_LANES-1:0] hit_q, miss_q;
    logic                 perf_q;

    logic [NUM_LANES-1:0] hits, misses, perfs;
    logic                 key_edge;
    logic                 any_hit, any_miss;
    logic [2:0]           mult;
    logic [3:0]           points;
    logic [SCORE_W:0]     score_sum;

    assign key_edge = (bus.keycode != prev_key_q);

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        lane_judge #(
            .Y_W     (Y_W),
            .WIN_LO  (WIN_LO),
            .WIN_HI  (WIN_HI),
            .PERF_LO (PERF_LO),
            .PERF_HI (PERF_HI),
            .KEY     (LANE_KEY[i])
        ) u_judge (
            .Clk          (Clk),
            .Reset_n      (Reset_n),
            .clear_i      (bus.clear),
            .note_y_i     (bus.note_y[i]),
            .note_valid_i (bus.note_valid[i]),
            .keycode_i    (bus.keycode),
            .key_edge_i   (key_edge),
            .hit_o        (hits[i]),
            .miss_o       (misses[i]),
            .perfect_o    (perfs[i])
        );
    end

    // Lanes have distinct keys, so at most one hit can occur per cycle.
    always_comb begin
        any_hit  = |hits;
        any_miss = |misses;
`ifdef SCORER_MULT_EN
        mult = mult_of(32'(combo_q));
`else
        mult = 3'd1;
`endif
        points    = any_hit ? 4'((|perfs) ? PTS_PERFECT : PTS_GOOD) * 4'(mult) : 4'd0;
        score_sum = {1'b0, score_q} + (SCORE_W+1)'(points);
        score_d   = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];

        // A miss anywhere breaks the streak; a simultaneous hit restarts it at 1.
        if (any_miss)
            combo_d = any_hit ? COMBO_W'(1) : '0;
        else if (any_hit && (combo_q != '1))
            combo_d = combo_q + COMBO_W'(1);
        else
            combo_d = combo_q;

        max_d = (combo_d > max_q) ? combo_d : max_q;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            prev_key_q <= '0;
            score_q    <= '0;
            combo_q    <= '0;
            max_q      <= '0;
            hit_q      <= '0;
            miss_q     <= '0;
            perf_q     <= 1'b0;
        end else if (bus.clear) begin
            prev_key_q <= '0;
            score_q    <= '0;
            combo_q    <= '0;
            max_q      <= '0;
            hit_q      <= '0;
            miss_q     <= '0;
            perf_q     <= 1'b0;
        end else begin
            prev_key_q <= bus.keycode;
            score_q    <= score_d;
            combo_q    <= combo_d;
            max_q      <= max_d;
            hit_q      <= hits;
            miss_q     <= misses;
            perf_q     <= |perfs;
        end
    end

    assign bus.score         = score_q;
    assign bus.combo         = combo_q;
    assign bus.max_combo     = max_q;
    assign bus.hit_pulse     = hit_q;
    assign bus.miss_pulse    = miss_q;
    assign bus.perfect_pulse = perf_q;

endmodule
